// File: rtl/dpe_timer_defs.sv
// Shared definitions for the DPE timer bank: channel state encodings and mode values.
package dpe_timer_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } ch_state_e;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/dpe_timer_ch.sv
// One timer channel: up-counter against a limit captured at start, one-shot or auto-reload,
// with registered running/timeout/expire outputs.
module dpe_timer_ch
    import dpe_timer_defs::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] load_val,
    output logic             running,
    output logic             timeout,
    output logic             expire
);

    ch_state_e        state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             mode_q, mode_d;
    logic             running_q, running_d;
    logic             timeout_q, timeout_d;
    logic             expire_q, expire_d;
    logic [WIDTH-1:0] cnt_inc;

    // cnt stays below limit, so the increment can never overflow WIDTH bits.
    assign cnt_inc = cnt_q + WIDTH'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        limit_d   = limit_q;
        mode_d    = mode_q;
        timeout_d = timeout_q;
        expire_d  = 1'b0;
        if (stop) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else if (start) begin
            limit_d = load_val;
            mode_d  = mode;
            cnt_d   = '0;
            if (load_val != '0) begin
                state_d   = ST_RUN;
                timeout_d = 1'b0;
            end else begin
                // A zero limit expires at once and always behaves as one-shot.
                state_d   = ST_DONE;
                timeout_d = 1'b1;
                expire_d  = 1'b1;
            end
        end else if (state_q == ST_RUN && tick) begin
            if (cnt_inc == limit_q) begin
                expire_d = 1'b1;
                cnt_d    = '0;
                if (mode_q == MODE_ONESHOT) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_inc;
            end
        end
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            limit_q   <= '0;
            mode_q    <= MODE_ONESHOT;
            running_q <= 1'b0;
            timeout_q <= 1'b0;
            expire_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            limit_q   <= limit_d;
            mode_q    <= mode_d;
            running_q <= running_d;
            timeout_q <= timeout_d;
            expire_q  <= expire_d;
        end
    end

    assign running = running_q;
    assign timeout = timeout_q;
    assign expire  = expire_q;

endmodule

// File: rtl/dpe_timer_bank.sv
// Bank of NUM_CH independent programmable timers sharing one tick enable.
module dpe_timer_bank
    import dpe_timer_defs::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       stop,
    input  logic [NUM_CH-1:0]       mode,
    input  logic [NUM_CH*WIDTH-1:0] load_val,
    output logic [NUM_CH-1:0]       running,
    output logic [NUM_CH-1:0]       timeout,
    output logic [NUM_CH-1:0]       expire
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        dpe_timer_ch #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick     (tick),
            .start    (start[i]),
            .stop     (stop[i]),
            .mode     (mode[i]),
            .load_val (load_val[i*WIDTH +: WIDTH]),
            .running  (running[i]),
            .timeout  (timeout[i]),
            .expire   (expire[i])
        );
    end

endmodule

// File: tb/tb_dpe_timer_bank.sv
// Self-checking bench: directed scenarios plus random traffic against a remaining-ticks model.
module tb_dpe_timer_bank;

    localparam int NC = 4;
    localparam int W  = 16;
    localparam int SW = 4;
    localparam int MC = NC + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tick = 1'b0;
    logic [NC-1:0]     start = '0, stop = '0, mode = '0;
    logic [NC*W-1:0]   load_val = '0;
    logic [NC-1:0]     running, timeout, expire;

    logic              s_start = 1'b0, s_stop = 1'b0, s_mode = 1'b0;
    logic [SW-1:0]     s_load = '0;
    logic [0:0]        s_running, s_timeout, s_expire;

    int n_tests = 0;
    int n_fail  = 0;

    // model: remaining ticks until expiry, counted down
    int rem [MC];
    int lim [MC];
    bit m_run [MC];
    bit m_done [MC];
    bit m_rel [MC];
    bit m_exp [MC];

    dpe_timer_bank #(.NUM_CH(NC), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop), .mode(mode),
        .load_val(load_val), .running(running), .timeout(timeout), .expire(expire)
    );

    dpe_timer_bank #(.NUM_CH(1), .WIDTH(SW)) dut_s (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(s_start), .stop(s_stop), .mode(s_mode),
        .load_val(s_load), .running(s_running), .timeout(s_timeout), .expire(s_expire)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < MC; c++) begin
            rem[c] = 0; lim[c] = 0;
            m_run[c] = 0; m_done[c] = 0; m_rel[c] = 0; m_exp[c] = 0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < MC; c++) begin
            bit st, sp, md;
            int ld;
            if (c < NC) begin
                st = start[c]; sp = stop[c]; md = mode[c]; ld = int'(load_val[c*W +: W]);
            end else begin
                st = s_start; sp = s_stop; md = s_mode; ld = int'(s_load);
            end
            m_exp[c] = 0;
            if (sp) begin
                m_run[c] = 0; m_done[c] = 0;
            end else if (st) begin
                if (ld == 0) begin
                    m_run[c] = 0; m_done[c] = 1; m_exp[c] = 1;
                end else begin
                    m_run[c] = 1; m_done[c] = 0; rem[c] = ld; lim[c] = ld; m_rel[c] = md;
                end
            end else if (m_run[c] && tick) begin
                rem[c]--;
                if (rem[c] == 0) begin
                    m_exp[c] = 1;
                    if (m_rel[c]) rem[c] = lim[c];
                    else begin
                        m_run[c] = 0; m_done[c] = 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [NC-1:0] er, et, ee;
        for (int c = 0; c < NC; c++) begin
            er[c] = m_run[c]; et[c] = m_done[c]; ee[c] = m_exp[c];
        end
        chk("running", 32'(running), 32'(er));
        chk("timeout", 32'(timeout), 32'(et));
        chk("expire", 32'(expire), 32'(ee));
        chk("s_running", 32'(s_running), 32'(m_run[NC]));
        chk("s_timeout", 32'(s_timeout), 32'(m_done[NC]));
        chk("s_expire", 32'(s_expire), 32'(m_exp[NC]));
    endtask

    // One clock: inputs already set by caller; strobes cleared afterwards.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        start = '0; stop = '0; s_start = 1'b0; s_stop = 1'b0;
    endtask

    task automatic start_ch(input int ch, input int ld, input bit md);
        start[ch] = 1'b1;
        mode[ch]  = md;
        load_val[ch*W +: W] = W'(ld);
    endtask

    initial begin
        int lat, e1, e2, cnt;
        model_reset();
        #12;
        chk("rst_running", 32'(running), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_expire", 32'(expire), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // one-shot, limit 5, tick every cycle
        start_ch(0, 5, 0); tick = 1'b1;
        cycle();
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (expire[0]) begin lat = i + 1; break; end
        end
        chk("oneshot_lat", 32'(lat), 5);
        chk("oneshot_run_low", 32'(running[0]), 0);
        cycle(); cycle();
        chk("oneshot_sticky", 32'(timeout[0]), 1);

        // auto-reload, limit 3, tick every 4th cycle
        tick = 1'b0; start_ch(1, 3, 1);
        cycle();
        e1 = -1; e2 = -1; cnt = 0;
        for (int k = 0; k < 60; k++) begin
            tick = (k % 4 == 3);
            cycle();
            if (expire[1]) begin
                cnt++;
                if (e1 < 0) e1 = k; else if (e2 < 0) e2 = k;
            end
        end
        chk("reload_period", 32'(e2 - e1), 12);
        chk("reload_count", 32'(cnt), 5);
        chk("reload_no_timeout", 32'(timeout[1]), 0);
        stop[1] = 1'b1; tick = 1'b0;
        cycle();
        cnt = 0;
        for (int k = 0; k < 24; k++) begin
            tick = (k % 4 == 3);
            cycle();
            if (expire[1]) cnt++;
        end
        chk("reload_stopped", 32'(cnt), 0);

        // priority: stop > start > tick at cnt = limit-1
        tick = 1'b1; start_ch(2, 4, 0);
        cycle(); cycle(); cycle(); cycle();
        stop[2] = 1'b1; start_ch(2, 4, 0);
        cycle();
        chk("prio_stop_run", 32'(running[2]), 0);
        chk("prio_stop_exp", 32'(expire[2]), 0);
        chk("prio_stop_to", 32'(timeout[2]), 0);
        start_ch(2, 4, 0);
        cycle(); cycle(); cycle(); cycle();
        start_ch(2, 4, 0);
        cycle();
        chk("prio_restart_exp", 32'(expire[2]), 0);
        chk("prio_restart_run", 32'(running[2]), 1);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (expire[2]) begin lat = i + 1; break; end
        end
        chk("prio_restart_lat", 32'(lat), 4);

        // zero limit, both modes
        for (int m = 0; m < 2; m++) begin
            start_ch(3, 0, 1'(m));
            cycle();
            chk("zero_expire", 32'(expire[3]), 1);
            chk("zero_timeout", 32'(timeout[3]), 1);
            cycle();
            chk("zero_single", 32'(expire[3]), 0);
        end
        stop[3] = 1'b1;
        cycle();

        // maximum limit on the 4-bit bank
        s_start = 1'b1; s_load = 4'hf; s_mode = 1'b0; tick = 1'b1;
        cycle();
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (s_expire[0]) begin lat = i + 1; break; end
        end
        chk("max_lat", 32'(lat), 15);

        // simultaneous expiry, mixed modes
        start_ch(0, 6, 0); start_ch(1, 6, 1);
        cycle();
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (expire[0] || expire[1]) begin lat = i + 1; break; end
        end
        chk("simul_pulse", 32'(expire[1:0]), 32'h3);
        chk("simul_lat", 32'(lat), 6);

        // asynchronous reset mid-count
        start_ch(3, 10, 0);
        cycle(); cycle(); cycle();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_running", 32'(running), 0);
        chk("arst_timeout", 32'(timeout), 0);
        chk("arst_expire", 32'(expire), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) cycle();

        // random traffic
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < NC; c++) begin
                int r;
                r = $urandom_range(0, 15);
                if (r == 0) stop[c] = 1'b1;
                else if (r < 3) start_ch(c, $urandom_range(0, 9), 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 19) == 0) s_stop = 1'b1;
            else if ($urandom_range(0, 9) == 0) begin
                s_start = 1'b1; s_load = 4'($urandom_range(0, 15)); s_mode = 1'($urandom_range(0, 1));
            end
            tick = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dpe_timer_bank.md
Name: dpe_timer_bank

Overview:
- Multi-channel, runtime-programmable timer bank for the device policy engine (DPE); replaces per-timer fixed-VALUE instances.
- Each channel supports one-shot or auto-reload mode, a limit loaded at start, and a shared external tick enable for the time base.
- Each channel outputs a registered expiry pulse and a sticky timeout level, consumed by the policy-engine state machine.

Parameters:
- NUM_CH, 4: number of independent timer channels (1..16).
- WIDTH, 16: counter and limit width in bits (2..32).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  time-base enable; counters advance only in cycles where tick=1.
- start  input  NUM_CH  per-channel start/restart strobe.
- stop  input  NUM_CH  per-channel stop/clear strobe.
- mode  input  NUM_CH  sampled at start: 0 = one-shot, 1 = auto-reload.
- load_val  input  NUM_CH*WIDTH  limit per channel, channel i at bits [i*WIDTH +: WIDTH]; sampled at start.
- running  output  NUM_CH  channel is in RUN.
- timeout  output  NUM_CH  sticky level: a one-shot channel has expired (DONE).
- expire  output  NUM_CH  one-cycle pulse on every expiry, in both modes.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state, all channels: IDLE, cnt=0, limit=0, mode_r=0, running=0, timeout=0, expire=0.
- Reset asserted mid-count aborts immediately with no expire pulse.
- Per-channel states: IDLE, RUN, DONE. Encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
- Priority each cycle: stop > start > tick.
- stop, from any state: next state IDLE, cnt=0, timeout=0, no expire pulse.
- start with load_val != 0:
  - limit <= load_val, mode_r <= mode, cnt <= 0, next state RUN.
  - Applies equally from RUN (restart) and from DONE.
  - A tick in the same cycle as start is not counted.
- start with load_val == 0:
  - Next state DONE, timeout=1, expire=1 one cycle after start, in either mode.
  - Auto-reload with limit 0 is not supported; the channel behaves as one-shot.
- RUN, tick=1, cnt+1 != limit: cnt <= cnt+1.
- RUN, tick=1, cnt+1 == limit: expire=1 in the next cycle.
  - mode_r=0: next state DONE, timeout=1.
  - mode_r=1: cnt <= 0, stay in RUN, timeout stays 0.
- Expiry latency: expire rises exactly one clk after the limit-th counted tick following start.
- RUN, tick=0: hold all state.
- DONE: hold timeout=1 until stop or start. Ticks are ignored.
- IDLE: ticks are ignored. Outputs are all 0.
- Arithmetic: cnt is WIDTH bits and never exceeds limit-1, so no wrap-around is possible. load_val = 2^WIDTH-1 is legal.
- Outputs running, timeout and expire are all registered; there are no combinational paths from inputs to outputs.
- Channels are fully independent. Simultaneous expiries on several channels produce simultaneous pulses.
- A start or stop on one channel does not affect any other channel.

Decomposition:
- Shared defines file dpe_timer_defs: state encodings, MODE_ONESHOT=1'b0, MODE_RELOAD=1'b1.
- Sub-module dpe_timer_ch: one channel holding state, cnt, limit, mode_r and its output registers.
- dpe_timer_bank instantiates NUM_CH copies in a generate loop and slices load_val per channel.

Test Plan:
- One-shot: NUM_CH=4, WIDTH=16, ch0 load_val=5, mode=0, tick every cycle.
  - expire[0] is a single pulse at cycle 6 after start; timeout[0] rises with it and stays 1; running[0] falls in the same cycle.
- Auto-reload with sparse tick: ch1 load_val=3, mode=1, tick every 4th cycle.
  - expire[1] pulses after every 3rd counted tick, i.e. period 12 clk.
  - timeout[1] stays 0 throughout. stop[1] ends pulsing; no further expire.
- Priority: ch2 running with cnt=limit-1.
  - Assert stop, start and tick in the same cycle: channel goes IDLE, no expire, timeout=0.
  - Repeat with start+tick only: restart with cnt=0 and no expire.
- Zero and maximum limit:
  - load_val=0: expire and timeout one cycle after start, in both modes.
  - WIDTH=4, load_val=15: expire after exactly 15 ticks.
- Reset and independence:
  - Assert rst_n=0 mid-count on ch3: all outputs 0 immediately, no pulse after release.
  - Concurrently, ch0 and ch1 started with equal limits expire in the same cycle.
